// File: rtl/i2s_receiver.sv
// I2S receiver: recovers slot timing from LRCLK, verifies frame length before trusting it,
// and publishes left/right samples together as a stereo pair.
module i2s_receiver #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32
) (
  input  logic                  BCLK,
  input  logic                  RESETN,
  input  logic                  LRCLK,
  input  logic                  SDATA,
  output logic [DATA_WIDTH-1:0] LEFT_DATA,
  output logic [DATA_WIDTH-1:0] RIGHT_DATA,
  output logic                  SAMPLE_VALID,
  output logic                  LOCKED,
  output logic                  FRAME_ERROR
);

  localparam int CNT_MAX = 2*SLOT_WIDTH - 1;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCK} state_t;

  state_t                state, state_nxt;
  logic                  good_cnt, good_nxt;
  logic                  ferr_nxt;

  logic                  lrclk_d;
  logic                  lr_edge;
  logic [CW-1:0]         cnt_q, cnt;
  logic                  slot_good;
  logic                  shift_en, cap;
  logic                  chan, slot_lock, left_ok;
  logic [DATA_WIDTH-1:0] shreg, word, left_hold;

  assign lr_edge = (LRCLK != lrclk_d);

  // cnt is the position of the current BCLK within the slot (edge cycle = 0, MSB = 1);
  // cnt_q holds the previous position, so on an edge it is the last position of the old slot.
  always_comb begin
    cnt = cnt_q;
    if (lr_edge)
      cnt = '0;
    else if (cnt_q != CW'(CNT_MAX))
      cnt = cnt_q + 1'b1;
  end

  assign slot_good = (cnt_q == CW'(SLOT_WIDTH - 1));
  assign shift_en  = !lr_edge && (cnt <= CW'(DATA_WIDTH));
  assign cap       = !lr_edge && (cnt == CW'(DATA_WIDTH));
  assign word      = {shreg[DATA_WIDTH-2:0], SDATA};

  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    ferr_nxt  = 1'b0;
    if (lr_edge) begin
      case (state)
        SEARCH: begin
          state_nxt = ACQUIRE;
          good_nxt  = 1'b0;
        end
        ACQUIRE: begin
          if (slot_good) begin
            if (good_cnt) begin
              state_nxt = LOCK;
              good_nxt  = 1'b0;
            end else begin
              good_nxt  = 1'b1;
            end
          end else begin
            good_nxt = 1'b0;
          end
        end
        LOCK: begin
          if (!slot_good) begin
            state_nxt = ACQUIRE;
            good_nxt  = 1'b0;
            ferr_nxt  = 1'b1;
          end
        end
        default: begin
          state_nxt = SEARCH;
          good_nxt  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge BCLK) begin
    if (!RESETN) begin
      state       <= SEARCH;
      good_cnt    <= 1'b0;
      LOCKED      <= 1'b0;
      FRAME_ERROR <= 1'b0;
    end else begin
      state       <= state_nxt;
      good_cnt    <= good_nxt;
      LOCKED      <= (state_nxt == LOCK);
      FRAME_ERROR <= ferr_nxt;
    end
  end

  // Loading lrclk_d during reset keeps release from looking like an edge.
  always_ff @(posedge BCLK) begin
    if (!RESETN) begin
      lrclk_d      <= LRCLK;
      cnt_q        <= '0;
      chan         <= 1'b0;
      slot_lock    <= 1'b0;
      left_ok      <= 1'b0;
      shreg        <= '0;
      left_hold    <= '0;
      LEFT_DATA    <= '0;
      RIGHT_DATA   <= '0;
      SAMPLE_VALID <= 1'b0;
    end else begin
      lrclk_d      <= LRCLK;
      cnt_q        <= cnt;
      SAMPLE_VALID <= 1'b0;

      if (lr_edge) begin
        chan      <= LRCLK;
        slot_lock <= (state_nxt == LOCK);
        shreg     <= '0;
      end else if (shift_en) begin
        shreg <= word;
      end

      // Leaving LOCK only happens on an edge, so it never collides with a capture.
      if (state == LOCK && state_nxt != LOCK) begin
        left_ok <= 1'b0;
      end else if (cap && slot_lock) begin
        if (!chan) begin
          left_hold <= word;
          left_ok   <= 1'b1;
        end else if (left_ok) begin
          LEFT_DATA    <= left_hold;
          RIGHT_DATA   <= word;
          SAMPLE_VALID <= 1'b1;
          left_ok      <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: lock, stereo capture, short slot, right-first lock,
// mid-frame reset and random padding bits.
module tb_i2s_receiver;

  logic        BCLK = 1'b0;
  logic        RESETN = 1'b0;
  logic        LRCLK = 1'b0;
  logic        SDATA = 1'b0;
  logic [23:0] LEFT_DATA, RIGHT_DATA;
  logic        SAMPLE_VALID, LOCKED, FRAME_ERROR;

  always #5 BCLK = ~BCLK;

  i2s_receiver #(.DATA_WIDTH(24), .SLOT_WIDTH(32)) dut (
    .BCLK(BCLK), .RESETN(RESETN), .LRCLK(LRCLK), .SDATA(SDATA),
    .LEFT_DATA(LEFT_DATA), .RIGHT_DATA(RIGHT_DATA), .SAMPLE_VALID(SAMPLE_VALID),
    .LOCKED(LOCKED), .FRAME_ERROR(FRAME_ERROR)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Background watch: outputs may only move with SAMPLE_VALID (outside reset).
  logic        rst_pos = 1'b0;
  logic [23:0] lprev = '0, rprev = '0;
  int          viol = 0;
  int          fe_total = 0;

  always @(posedge BCLK) rst_pos = RESETN;

  always @(negedge BCLK) begin
    if (rst_pos && SAMPLE_VALID !== 1'b1 && (LEFT_DATA !== lprev || RIGHT_DATA !== rprev))
      viol++;
    if (FRAME_ERROR === 1'b1)
      fe_total++;
    lprev = LEFT_DATA;
    rprev = RIGHT_DATA;
  end

  logic        lk_edge, fe_edge;
  int          vcnt, vpos;
  logic [23:0] snap_l, snap_r;
  logic        snap_lk, snap_v, snap_fe;

  // Drives one slot: position 0 and positions past 24 carry random filler.
  task automatic send_slot(input logic ch, input logic [23:0] d, input int len, input int rst_at);
    vcnt = 0;
    vpos = -1;
    for (int i = 0; i < len; i++) begin
      @(negedge BCLK);
      if (i == 1) begin
        lk_edge = LOCKED;
        fe_edge = FRAME_ERROR;
      end
      if (SAMPLE_VALID === 1'b1) begin
        vcnt++;
        vpos = i;
      end
      if (rst_at >= 0 && i == rst_at + 1) begin
        snap_l  = LEFT_DATA;
        snap_r  = RIGHT_DATA;
        snap_lk = LOCKED;
        snap_v  = SAMPLE_VALID;
        snap_fe = FRAME_ERROR;
      end
      if (rst_at >= 0 && i == rst_at)     RESETN = 1'b0;
      if (rst_at >= 0 && i == rst_at + 3) RESETN = 1'b1;
      LRCLK = ch;
      SDATA = (i >= 1 && i <= 24) ? d[24-i] : 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    repeat (4) @(negedge BCLK);
    chk("rst_left",  32'(LEFT_DATA), 32'h0);
    chk("rst_right", 32'(RIGHT_DATA), 32'h0);
    chk("rst_valid", 32'(SAMPLE_VALID), 32'h0);
    chk("rst_lock",  32'(LOCKED), 32'h0);
    chk("rst_ferr",  32'(FRAME_ERROR), 32'h0);
    RESETN = 1'b1;

    send_slot(1'b0, 24'h0, 5, -1);
    send_slot(1'b1, 24'h555555, 32, -1); chk("e1_lock", 32'(lk_edge), 32'h0);
    send_slot(1'b0, 24'hAAAAAA, 32, -1); chk("e2_lock", 32'(lk_edge), 32'h0);
    send_slot(1'b1, 24'h0C0C0C, 32, -1); chk("e3_lock", 32'(lk_edge), 32'h1);
    chk("rfirst_vcnt", 32'(vcnt), 32'h0);
    send_slot(1'b0, 24'hABCDEF, 32, -1); chk("l1_vcnt", 32'(vcnt), 32'h0);
    send_slot(1'b1, 24'h123456, 32, -1);
    chk("p1_vcnt", 32'(vcnt), 32'h1);
    chk("p1_vpos", 32'(vpos), 32'd25);
    chk("p1_left", 32'(LEFT_DATA), 32'hABCDEF);
    chk("p1_right", 32'(RIGHT_DATA), 32'h123456);
    chk("lock_ferr", 32'(fe_total), 32'h0);

    send_slot(1'b0, 24'h111111, 31, -1); chk("short_vcnt", 32'(vcnt), 32'h0);
    send_slot(1'b1, 24'h222222, 32, -1);
    chk("short_ferr", 32'(fe_edge), 32'h1);
    chk("short_lock", 32'(lk_edge), 32'h0);
    chk("acq1_vcnt", 32'(vcnt), 32'h0);
    send_slot(1'b0, 24'h333333, 32, -1);
    chk("acq2_lock", 32'(lk_edge), 32'h0);
    chk("acq2_vcnt", 32'(vcnt), 32'h0);
    send_slot(1'b1, 24'h444444, 32, -1);
    chk("relock", 32'(lk_edge), 32'h1);
    chk("relock_vcnt", 32'(vcnt), 32'h0);
    send_slot(1'b0, 24'h0F0F0F, 32, -1); chk("l2_vcnt", 32'(vcnt), 32'h0);
    send_slot(1'b1, 24'hF0F0F0, 32, -1);
    chk("p2_vcnt", 32'(vcnt), 32'h1);
    chk("p2_left", 32'(LEFT_DATA), 32'h0F0F0F);
    chk("p2_right", 32'(RIGHT_DATA), 32'hF0F0F0);
    chk("ferr_once", 32'(fe_total), 32'h1);

    send_slot(1'b0, 24'h999999, 32, 10);
    chk("mrst_left",  32'(snap_l), 32'h0);
    chk("mrst_right", 32'(snap_r), 32'h0);
    chk("mrst_lock",  32'(snap_lk), 32'h0);
    chk("mrst_valid", 32'(snap_v), 32'h0);
    chk("mrst_ferr",  32'(snap_fe), 32'h0);
    send_slot(1'b1, 24'h765432, 32, -1); chk("r_e1_lock", 32'(lk_edge), 32'h0);
    send_slot(1'b0, 24'h135791, 32, -1); chk("r_e2_lock", 32'(lk_edge), 32'h0);
    send_slot(1'b1, 24'h246802, 32, -1);
    chk("r_e3_lock", 32'(lk_edge), 32'h1);
    chk("r_e3_vcnt", 32'(vcnt), 32'h0);
    send_slot(1'b0, 24'h800001, 32, -1);
    send_slot(1'b1, 24'h7FFFFE, 32, -1);
    chk("p3_vcnt", 32'(vcnt), 32'h1);
    chk("p3_left", 32'(LEFT_DATA), 32'h800001);
    chk("p3_right", 32'(RIGHT_DATA), 32'h7FFFFE);
    send_slot(1'b0, 24'h0, 4, -1);

    chk("lone_change", 32'(viol), 32'h0);
    chk("ferr_total", 32'(fe_total), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
